writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 The module SHALL have parameter W, default 8: data path width.
REQ-002 The module SHALL have parameter D, default 3: register address width.
REQ-003 The module SHALL have parameter DEPTH, default 4: pending-write queue depth (power of two, at least 2).
REQ-004 Port Clk  input  1: single clock, all state updates on the rising edge.
REQ-005 Port Reset_n  input  1: reset, asynchronous assert, active-low.
REQ-006 Port AluValid  input  1: ALU result write request this cycle.
REQ-007 Port AluAddr  input  D: ALU destination register.
REQ-008 Port AluData  input  W: ALU result.
REQ-009 Port MemValid  input  1: data-memory load write request this cycle.
REQ-010 Port MemAddr  input  D: load destination register.
REQ-011 Port MemData  input  W: load data.
REQ-012 Port HazAddr  input  D: source register queried by decode.
REQ-013 Port HazHit  output  1: combinational; HazAddr has a write outstanding.
REQ-014 Port Stall  output  1: registered; upstream holds new requests.
REQ-015 Port Overflow  output  1: registered, sticky; a request was dropped.
REQ-016 Port WriteEn  output  1: registered register-file write enable.
REQ-017 Port Waddr  output  D: registered register-file write address.
REQ-018 Port DataIn  output  W: registered register-file write data.

Function
REQ-019 The block SHALL issue at most one register-file write per cycle, through WriteEn/Waddr/DataIn.
REQ-020 Age order SHALL be: queue head (oldest), then the Mem request, then the ALU request; Mem is older than ALU in the same cycle.
REQ-021 At each edge the output register SHALL load the oldest available request with WriteEn=1, or WriteEn=0 when none is available; Waddr/DataIn SHALL hold when WriteEn goes 0.
REQ-022 Requests not selected at an edge SHALL be pushed into the queue in age order; pop and up to two pushes SHALL occur in the same edge.
REQ-023 Latency SHALL be 1 cycle for a lone request with an empty queue: a request at edge N gives WriteEn=1 in cycle N+1.
REQ-024 Stall SHALL be 1 whenever the registered occupancy is at least DEPTH-1.
REQ-025 A request presented while Stall=1 SHALL be dropped without write and SHALL set Overflow, which stays 1 until reset.
REQ-026 Occupancy SHALL never exceed DEPTH; read and write pointers SHALL wrap modulo DEPTH.
REQ-027 HazHit SHALL be 1 when HazAddr equals the address of any valid queue entry, or equals Waddr while WriteEn=1, or equals an incoming valid AluAddr/MemAddr.
REQ-028 Writes to address 0 SHALL be treated like any other address.
REQ-029 Two same-address requests SHALL both issue, in age order (no coalescing); the younger data lands last.

Reset
REQ-030 Reset_n=0 SHALL asynchronously clear WriteEn, Waddr, DataIn, Stall, Overflow, occupancy and pointers to 0.
REQ-031 Queued requests SHALL be discarded on reset, including mid-drain.
REQ-032 Requests present during reset SHALL be ignored.
REQ-033 With Reset_n=1 and no requests, all outputs SHALL hold their reset values, with HazHit=0.

Verification
REQ-034 Lone ALU write: AluValid=1, AluAddr=3, AluData=0x5A at edge N -> WriteEn=1, Waddr=3, DataIn=0x5A in cycle N+1 only.
REQ-035 Simultaneous: Mem(2,0x11) and ALU(5,0x22) at edge N -> (2,0x11) in N+1, (5,0x22) in N+2, then WriteEn=0.
REQ-036 Fill: both sources valid for 4 consecutive cycles -> Stall rises at occupancy 3, dropped requests set Overflow=1, and the accepted writes drain in age order with no loss.
REQ-037 Hazard: queue holds address 6, HazAddr=6 -> HazHit=1; after the write issues and clears -> HazHit=0.
REQ-038 Reset mid-drain: queue with 3 entries, Reset_n=0 between edges -> WriteEn=0 immediately; after release no queued write issues.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU and load writes into one register-file write port,
// queuing the losers in age order and flagging outstanding writes to decode.
module writeback_arbiter #(
  parameter int W     = 8,
  parameter int D     = 3,
  parameter int DEPTH = 4
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         AluValid,
  input  logic [D-1:0] AluAddr,
  input  logic [W-1:0] AluData,
  input  logic         MemValid,
  input  logic [D-1:0] MemAddr,
  input  logic [W-1:0] MemData,
  input  logic [D-1:0] HazAddr,
  output logic         HazHit,
  output logic         Stall,
  output logic         Overflow,
  output logic         WriteEn,
  output logic [D-1:0] Waddr,
  output logic [W-1:0] DataIn
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [D-1:0]  q_addr [DEPTH];
  logic [W-1:0]  q_data [DEPTH];
  logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          we_reg, stall_reg, ovf_reg;
  logic [D-1:0]  waddr_reg;
  logic [W-1:0]  data_reg;

  logic          alu_acc, mem_acc, pop;
  logic          sel_valid, push0_valid, push1_valid;
  logic [D-1:0]  sel_addr, push0_addr, push1_addr;
  logic [W-1:0]  sel_data, push0_data, push1_data;
  logic [1:0]    n_push;
  logic [DEPTH-1:0] entry_hit;

  // Requests arriving while stalled never enter the datapath.
  assign alu_acc = AluValid & ~stall_reg;
  assign mem_acc = MemValid & ~stall_reg;
  assign pop     = (count_reg != '0);

  always_comb begin
    sel_valid   = 1'b0;
    sel_addr    = waddr_reg;
    sel_data    = data_reg;
    push0_valid = 1'b0;
    push0_addr  = MemAddr;
    push0_data  = MemData;
    push1_valid = 1'b0;
    push1_addr  = AluAddr;
    push1_data  = AluData;
    if (pop) begin
      sel_valid = 1'b1;
      sel_addr  = q_addr[rd_ptr_reg];
      sel_data  = q_data[rd_ptr_reg];
      if (mem_acc) begin
        push0_valid = 1'b1;
        push1_valid = alu_acc;
      end else if (alu_acc) begin
        push0_valid = 1'b1;
        push0_addr  = AluAddr;
        push0_data  = AluData;
      end
    end else if (mem_acc) begin
      sel_valid   = 1'b1;
      sel_addr    = MemAddr;
      sel_data    = MemData;
      push0_valid = alu_acc;
      push0_addr  = AluAddr;
      push0_data  = AluData;
    end else if (alu_acc) begin
      sel_valid = 1'b1;
      sel_addr  = AluAddr;
      sel_data  = AluData;
    end
  end

  assign n_push     = {1'b0, push0_valid} + {1'b0, push1_valid};
  assign count_next = count_reg - CW'(pop) + CW'(n_push);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      we_reg     <= 1'b0;
      waddr_reg  <= '0;
      data_reg   <= '0;
      stall_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      rd_ptr_reg <= rd_ptr_reg + AW'(pop);
      wr_ptr_reg <= wr_ptr_reg + AW'(n_push);
      count_reg  <= count_next;
      we_reg     <= sel_valid;
      waddr_reg  <= sel_addr;
      data_reg   <= sel_data;
      stall_reg  <= (count_next >= CW'(DEPTH - 1));
      if (stall_reg && (AluValid || MemValid))
        ovf_reg <= 1'b1;
    end
  end

  // Queue storage needs no reset: validity comes only from the pointers.
  always_ff @(posedge Clk) begin
    if (push0_valid) begin
      q_addr[wr_ptr_reg] <= push0_addr;
      q_data[wr_ptr_reg] <= push0_data;
    end
    if (push1_valid) begin
      q_addr[wr_ptr_reg + PTR_ONE] <= push1_addr;
      q_data[wr_ptr_reg + PTR_ONE] <= push1_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_haz
      logic [AW-1:0] offset;
      assign offset        = AW'(gi) - rd_ptr_reg;
      assign entry_hit[gi] = ({1'b0, offset} < count_reg) && (q_addr[gi] == HazAddr);
    end
  endgenerate

  assign HazHit = (|entry_hit)
                | (we_reg && (waddr_reg == HazAddr))
                | (AluValid && (AluAddr == HazAddr))
                | (MemValid && (MemAddr == HazAddr));

  assign Stall    = stall_reg;
  assign Overflow = ovf_reg;
  assign WriteEn  = we_reg;
  assign Waddr    = waddr_reg;
  assign DataIn   = data_reg;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed vector table, reset-mid-drain sequence,
// and random traffic against a queue-based reference model.
module tb_writeback_arbiter;
  localparam int W = 8;
  localparam int D = 3;
  localparam int DEPTH = 4;

  logic         Clk, Reset_n;
  logic         AluValid, MemValid;
  logic [D-1:0] AluAddr, MemAddr, HazAddr;
  logic [W-1:0] AluData, MemData;
  logic         HazHit, Stall, Overflow, WriteEn;
  logic [D-1:0] Waddr;
  logic [W-1:0] DataIn;

  writeback_arbiter #(.W(W), .D(D), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .AluValid(AluValid), .AluAddr(AluAddr), .AluData(AluData),
    .MemValid(MemValid), .MemAddr(MemAddr), .MemData(MemData),
    .HazAddr(HazAddr), .HazHit(HazHit), .Stall(Stall), .Overflow(Overflow),
    .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic         av; logic [D-1:0] aa; logic [W-1:0] ad;
    logic         mv; logic [D-1:0] ma; logic [W-1:0] md;
    logic [D-1:0] ha; logic hit;
    logic         we; logic [D-1:0] wa; logic [W-1:0] wd;
    logic         st; logic ov;
  } vec_t;

  typedef struct { logic [D-1:0] a; logic [W-1:0] d; } wr_t;

  // Reference model: list of accepted, not yet issued writes, oldest first.
  wr_t          pend[$];
  logic         m_we, m_stall, m_ovf;
  logic [D-1:0] m_waddr;
  logic [W-1:0] m_data;

  task automatic model_reset();
    pend.delete();
    m_we = 0; m_stall = 0; m_ovf = 0; m_waddr = '0; m_data = '0;
  endtask

  function automatic logic model_hit(input logic av, input logic [D-1:0] aa,
                                     input logic mv, input logic [D-1:0] ma,
                                     input logic [D-1:0] ha);
    logic h;
    h = (av && aa == ha) || (mv && ma == ha) || (m_we && m_waddr == ha);
    foreach (pend[i]) if (pend[i].a == ha) h = 1'b1;
    return h;
  endfunction

  task automatic model_step(input logic av, input logic [D-1:0] aa, input logic [W-1:0] ad,
                            input logic mv, input logic [D-1:0] ma, input logic [W-1:0] md);
    wr_t e;
    if (pend.size() >= DEPTH - 1) begin
      if (av || mv) m_ovf = 1'b1;
    end else begin
      if (mv) begin e.a = ma; e.d = md; pend.push_back(e); end
      if (av) begin e.a = aa; e.d = ad; pend.push_back(e); end
    end
    if (pend.size() > 0) begin
      e = pend.pop_front();
      m_we = 1'b1; m_waddr = e.a; m_data = e.d;
    end else begin
      m_we = 1'b0;
    end
    m_stall = (pend.size() >= DEPTH - 1);
  endtask

  task automatic drive(input logic av, input logic [D-1:0] aa, input logic [W-1:0] ad,
                       input logic mv, input logic [D-1:0] ma, input logic [W-1:0] md,
                       input logic [D-1:0] ha);
    AluValid = av; AluAddr = aa; AluData = ad;
    MemValid = mv; MemAddr = ma; MemData = md;
    HazAddr = ha;
  endtask

  task automatic do_reset();
    drive(1'b1, 3'd1, 8'hFF, 1'b1, 3'd2, 8'hEE, 3'd0);
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_we", WriteEn, 0);
    check("reset_stall", Stall, 0);
    check("reset_ovf", Overflow, 0);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd0);
    #2 Reset_n = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic rand_cycle(input int pct);
    logic av, mv;
    logic [D-1:0] aa, ma, ha;
    logic [W-1:0] ad, md;
    av = ($urandom_range(99) < pct); mv = ($urandom_range(99) < pct);
    aa = D'($urandom); ma = D'($urandom); ha = D'($urandom);
    ad = W'($urandom); md = W'($urandom);
    drive(av, aa, ad, mv, ma, md, ha);
    #2;
    check("rnd_hazhit", HazHit, model_hit(av, aa, mv, ma, ha));
    model_step(av, aa, ad, mv, ma, md);
    @(posedge Clk); #1;
    check("rnd_we", WriteEn, m_we);
    check("rnd_waddr", Waddr, m_waddr);
    check("rnd_data", DataIn, m_data);
    check("rnd_stall", Stall, m_stall);
    check("rnd_ovf", Overflow, m_ovf);
  endtask

  vec_t vecs[18];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            av   aa    ad      mv   ma    md     ha   hit   we   wa    wd     st   ov
    vecs[0]  = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 3'd0,1'b0, 1'b0,3'd0,8'h00, 1'b0,1'b0};
    vecs[1]  = '{1'b1,3'd3,8'h5A, 1'b0,3'd0,8'h00, 3'd3,1'b1, 1'b1,3'd3,8'h5A, 1'b0,1'b0};
    vecs[2]  = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 3'd3,1'b1, 1'b0,3'd3,8'h5A, 1'b0,1'b0};
    vecs[3]  = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 3'd3,1'b0, 1'b0,3'd3,8'h5A, 1'b0,1'b0};
    vecs[4]  = '{1'b1,3'd5,8'h22, 1'b1,3'd2,8'h11, 3'd1,1'b0, 1'b1,3'd2,8'h11, 1'b0,1'b0};
    vecs[5]  = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 3'd5,1'b1, 1'b1,3'd5,8'h22, 1'b0,1'b0};
    vecs[6]  = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 3'd5,1'b1, 1'b0,3'd5,8'h22, 1'b0,1'b0};
    vecs[7]  = '{1'b1,3'd2,8'hA2, 1'b1,3'd1,8'hA1, 3'd6,1'b0, 1'b1,3'd1,8'hA1, 1'b0,1'b0};
    vecs[8]  = '{1'b1,3'd4,8'hB2, 1'b1,3'd3,8'hB1, 3'd2,1'b1, 1'b1,3'd2,8'hA2, 1'b0,1'b0};
    vecs[9]  = '{1'b1,3'd7,8'hC2, 1'b1,3'd6,8'hC1, 3'd0,1'b0, 1'b1,3'd3,8'hB1, 1'b1,1'b0};
    vecs[10] = '{1'b1,3'd0,8'hD2, 1'b1,3'd0,8'hD1, 3'd0,1'b1, 1'b1,3'd4,8'hB2, 1'b0,1'b1};
    vecs[11] = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 3'd6,1'b1, 1'b1,3'd6,8'hC1, 1'b0,1'b1};
    vecs[12] = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 3'd6,1'b1, 1'b1,3'd7,8'hC2, 1'b0,1'b1};
    vecs[13] = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 3'd6,1'b0, 1'b0,3'd7,8'hC2, 1'b0,1'b1};
    vecs[14] = '{1'b1,3'd0,8'hE2, 1'b1,3'd0,8'hE1, 3'd0,1'b1, 1'b1,3'd0,8'hE1, 1'b0,1'b1};
    vecs[15] = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 3'd0,1'b1, 1'b1,3'd0,8'hE2, 1'b0,1'b1};
    vecs[16] = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 3'd0,1'b1, 1'b0,3'd0,8'hE2, 1'b0,1'b1};
    vecs[17] = '{1'b0,3'd0,8'h00, 1'b0,3'd0,8'h00, 3'd0,1'b0, 1'b0,3'd0,8'hE2, 1'b0,1'b1};

    Reset_n = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd0);
    #1;
    do_reset();

    // Directed table: lone write, simultaneous pair, fill/overflow, hazard, address 0.
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].mv, vecs[i].ma, vecs[i].md, vecs[i].ha);
      #2;
      check($sformatf("v%0d_hazhit", i), HazHit, vecs[i].hit);
      @(posedge Clk); #1;
      check($sformatf("v%0d_we", i), WriteEn, vecs[i].we);
      check($sformatf("v%0d_waddr", i), Waddr, vecs[i].wa);
      check($sformatf("v%0d_data", i), DataIn, vecs[i].wd);
      check($sformatf("v%0d_stall", i), Stall, vecs[i].st);
      check($sformatf("v%0d_ovf", i), Overflow, vecs[i].ov);
      $display("vec %0d: we=%0b waddr=%0d data=%02h stall=%0b ovf=%0b hit=%0b",
               i, WriteEn, Waddr, DataIn, Stall, Overflow, vecs[i].hit);
    end

    // Reset mid-drain: build three queued entries, then reset between edges.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, D'(i), W'(8'h40 + i), 1'b1, D'(i + 4), W'(8'h80 + i), 3'd0);
      @(posedge Clk); #1;
    end
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd0);
    check("predrain_stall", Stall, 1);
    check("predrain_we", WriteEn, 1);
    #2 Reset_n = 1'b0;
    #1;
    check("midrst_we", WriteEn, 0);
    check("midrst_stall", Stall, 0);
    check("midrst_waddr", Waddr, 0);
    check("midrst_data", DataIn, 0);
    drive(1'b1, 3'd3, 8'h77, 1'b1, 3'd4, 8'h66, 3'd0);
    @(posedge Clk); #1;
    check("inrst_we", WriteEn, 0);
    drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd4);
    #2 Reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge Clk); #1;
      check("postrst_we", WriteEn, 0);
      check("postrst_hazhit", HazHit, 0);
      $display("post-reset cycle %0d: we=%0b stall=%0b", i, WriteEn, Stall);
    end

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      rand_cycle((i < 200) ? 70 : 35);
      $display("rnd %0d: we=%0b waddr=%0d data=%02h stall=%0b ovf=%0b",
               i, WriteEn, Waddr, DataIn, Stall, Overflow);
    end
    for (int i = 0; i < 8; i++) rand_cycle(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
